data_bus_ctrl: RTL
==================

# data_bus_ctrl

Data-side memory controller that sits directly downstream of the RV32I core's load/store port. It consumes the core's `addr`/`dataBusOut`/`wrEn`/`rdEn`/`RamMode` outputs and decodes each access to one of two targets: an internal word-organised data RAM or a memory-mapped UART transmit register bank. It returns load data on `dataBusIn` with the fixed two-cycle latency the core's write-back stage expects.

## Interface
- `RAM_WORDS`, default 1024: data RAM depth in 32-bit words; power of two.
- `TXFIFO_DEPTH`, default 4: UART TX FIFO entries; power of two, ≥2.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rstB` in 1: reset. One clock; reset is asynchronous and active-low.
- `clkEn` in 1: access qualifier; `rdEn`/`wrEn` are ignored while low.
- `addr` in 32: byte address of the current access.
- `dataBusOut` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `wrEn` in 1: store request this cycle.
- `rdEn` in 1: load request this cycle.
- `RamMode` in 4: {byte, half, word, unsigned}.
- `dataBusIn` out 32: load result, extended to 32 bits.
- `dataBusInEn` out 1: `dataBusIn` is valid this cycle.
- `txData` out 8: head byte of the TX FIFO.
- `txValid` out 1: FIFO not empty.
- `txReady` in 1: the UART accepts the head byte when `txValid && txReady` at a clock edge.

## Operation
- An access is accepted when `clkEn && (rdEn || wrEn)`. If `rdEn` and `wrEn` are both high, the write is performed and no read response is produced.
- Decode:
  - `addr[31:28]==4'h1` selects UART.
  - Every other address selects RAM.
  - The RAM word index is `addr[log2(RAM_WORDS)+1:2]`, so RAM addresses wrap modulo the RAM size.
- Mode validity: exactly one of {byte, half, word} must be set. Any other `RamMode` makes the access a no-op. A read in that case returns 0 with `dataBusInEn=1`, and no error is flagged.
- Misalignment:
  - A half access with `addr[0]=1` is misaligned.
  - A word access with `addr[1:0]!=0` is misaligned.
  - A misaligned write is dropped. A misaligned read returns 0 with `dataBusInEn=1`.
  - Either case sets sticky `misalign`.
- RAM store: a byte-lane write using `addr[1:0]`. Byte writes lane `addr[1:0]`; half writes lanes `{addr[1],0}` and `{addr[1],1}`; word writes all four lanes. Other bytes are untouched.
- RAM load: select the lane(s) by `addr[1:0]`. Zero-extend if `unsigned=1`, otherwise sign-extend from bit 7 or bit 15.
- UART register map, selected by `addr[3:2]`; all accesses here are word-mode only, and any other mode is treated as a no-op:
  - 0 TXDATA:
    - Write pushes `dataBusOut[7:0]` into the FIFO. If the FIFO is full, the byte is dropped and sticky `overflow` is set.
    - Read returns 0.
  - 1 STATUS:
    - Read returns {28'b0, overflow, misalign, empty, full}.
    - Write with a bit set clears the corresponding sticky flag: `dataBusOut[2]` clears `misalign`, `dataBusOut[3]` clears `overflow`.
    - If a set and a clear of the same flag occur in the same cycle, the set wins.
  - 2 and 3: reads return 0; writes are ignored.
- FIFO behaviour:
  - Pop occurs when `txValid && txReady`.
  - A push and pop in the same cycle while full are both performed, and no overflow is flagged.
  - Read and write pointers wrap modulo `TXFIFO_DEPTH`; an occupancy counter distinguishes full from empty.
- RAM contents are not reset.

## Timing
- Load issued in cycle N, with the address valid combinationally during N:
  - Edge ending N: synchronous RAM read. Lane, mode and target are captured into stage 1.
  - Edge ending N+1: extension and formatting registered into stage 2.
  - Cycle N+2: `dataBusIn` holds the result and `dataBusInEn=1` for exactly one cycle.
- Latency is fixed at 2 with no back-pressure, and the pipeline advances every cycle regardless of `clkEn`. Back-to-back loads produce one response per cycle.
- Stores commit at the edge ending the issue cycle. A load to the same word issued in N+1 returns the new data.
- A UART STATUS read reflects state at the edge ending N. It includes a push accepted in the same cycle N only through the following cycle's state.
- `txValid`/`txData` update on the edge after a push. An empty FIFO never presents `txValid`.
- Values while `rstB` is low:
  - `dataBusIn=0`, `dataBusInEn=0`, `txValid=0`, `txData=0`.
  - FIFO empty; `misalign=0`, `overflow=0`.
  - Both pipeline stages invalid.
- Reset asserted mid-load discards the pending response: no `dataBusInEn` pulse occurs after reset is released.
- While `dataBusInEn=0`, `dataBusIn` is 0.

## Test plan
- Word store then byte loads: SW 0x80FF7F01 @0x100. LB @0x100 returns 0x00000001 at N+2. LB @0x101 returns 0x0000007F. LB @0x103 returns 0xFFFFFF80. LBU @0x103 returns 0x00000080.
- Half store, lanes and extension:
  - SH 0xBEEF @0x202 over existing 0x11223344. LW @0x200 returns 0xBEEF3344.
  - LH @0x202 returns 0xFFFFBEEF. LHU @0x202 returns 0x0000BEEF.
  - Back-to-back LW, LH, LB produce three consecutive `dataBusInEn` cycles.
- Misalign: LW @0x101 returns 0 with `dataBusInEn=1`. STATUS read returns bit2=1. Write STATUS 0x4, then read STATUS: bit2=0. SH @0x301 leaves RAM unchanged.
- UART FIFO, depth 4, `txReady=0`:
  - 5 TXDATA writes 0x41..0x45. STATUS = 0b1001 (full, overflow). `txData`=0x41.
  - Raise `txReady`: 0x41..0x44 pop in order, then `txValid`=0.
  - Full FIFO with push and pop in the same cycle: no overflow, count unchanged.
- Control edges:
  - `rdEn`=1 with `clkEn`=0: no response.
  - `rdEn`+`wrEn` together: write performed, `dataBusInEn` stays 0.
  - Address 0x1000 with `RAM_WORDS`=1024 aliases address 0x0.
- Reset mid-load: assert `rstB`=0 at N+1 of a load. All outputs read 0 immediately, no response after release, FIFO empty.

Source files
------------

// File: rtl/data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl
//   Data-side memory controller for an RV32I load/store port. Each accepted
//   access is decoded to either a word-organised data RAM or a small UART
//   transmit register bank (TXDATA / STATUS). Load data returns with a fixed
//   two-cycle latency; the pipeline never stalls.
//
// Ports
//   clk          system clock, rising edge
//   rstB         asynchronous active-low reset
//   clkEn        access qualifier for rdEn / wrEn
//   addr         byte address of the current access
//   dataBusOut   store data, right-aligned
//   wrEn, rdEn   store / load request (write wins when both are high)
//   RamMode      {byte, half, word, unsigned}
//   dataBusIn    load result (0 whenever dataBusInEn is low)
//   dataBusInEn  one-cycle valid strobe for dataBusIn
//   txData       head byte of the UART TX FIFO
//   txValid      TX FIFO not empty
//   txReady      UART consumes the head byte when txValid && txReady
// -----------------------------------------------------------------------------
module data_bus_ctrl #(
    parameter int RAM_WORDS    = 1024,
    parameter int TXFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstB,
    input  logic        clkEn,
    input  logic [31:0] addr,
    input  logic [31:0] dataBusOut,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic [3:0]  RamMode,
    output logic [31:0] dataBusIn,
    output logic        dataBusInEn,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(TXFIFO_DEPTH);
    localparam int CW = $clog2(TXFIFO_DEPTH + 1);

    // ---------------- access decode ----------------
    logic          w_accept, w_wr, w_rd;
    logic          w_is_byte, w_is_half, w_is_word, w_mode_ok, w_misalign;
    logic          w_uart, w_uart_ok, w_ram_ok;
    logic          w_ram_wr, w_ram_rd, w_push_req, w_stat_wr, w_stat_rd;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_accept  = clkEn && (rdEn || wrEn);
    assign w_wr      = w_accept && wrEn;
    assign w_rd      = w_accept && rdEn && !wrEn;

    assign w_is_byte = RamMode[3];
    assign w_is_half = RamMode[2];
    assign w_is_word = RamMode[1];
    assign w_mode_ok = (RamMode[3:1] == 3'b100) || (RamMode[3:1] == 3'b010) ||
                       (RamMode[3:1] == 3'b001);
    // Alignment is judged for any valid-mode access, whichever target it hits.
    assign w_misalign = w_mode_ok && ((w_is_half && addr[0]) ||
                                      (w_is_word && (addr[1:0] != 2'b00)));

    assign w_uart    = (addr[31:28] == 4'h1);
    assign w_uart_ok = w_uart && w_mode_ok && w_is_word && !w_misalign;
    assign w_ram_ok  = !w_uart && w_mode_ok && !w_misalign;

    assign w_ram_wr   = w_wr && w_ram_ok;
    assign w_ram_rd   = w_rd && w_ram_ok;
    assign w_push_req = w_wr && w_uart_ok && (addr[3:2] == 2'd0);
    assign w_stat_wr  = w_wr && w_uart_ok && (addr[3:2] == 2'd1);
    assign w_stat_rd  = w_rd && w_uart_ok && (addr[3:2] == 2'd1);

    // Upper address bits above the RAM window are don't-care, so RAM aliases.
    assign w_idx         = addr[AW+1:2];
    assign w_unused_addr = &{1'b0, addr[27:AW+2]};

    // ---------------- RAM ----------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] r_mem [RAM_WORDS];
    logic [31:0] r_rdata;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_be    = 4'b0000;
        w_wdata = dataBusOut;
        if (w_is_byte) begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{dataBusOut[7:0]}};
        end else if (w_is_half) begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{dataBusOut[15:0]}};
        end else if (w_is_word) begin
            w_be    = 4'b1111;
        end
    end

    // NOTE: the RAM array and its read register carry no reset; contents are
    // undefined until written, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[w_idx];
    end

    // ---------------- TX FIFO and sticky flags ----------------
    logic [7:0]    r_fifo [TXFIFO_DEPTH];
    logic [FW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_misalign, r_overflow;
    logic          w_full, w_empty, w_pop, w_push, w_ovf_set;

    assign w_full    = (r_count == CW'(TXFIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && txReady;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= dataBusOut[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // Set has priority over a same-cycle clear.
            if (w_accept && w_misalign)            r_misalign <= 1'b1;
            else if (w_stat_wr && dataBusOut[2])   r_misalign <= 1'b0;
            if (w_ovf_set)                         r_overflow <= 1'b1;
            else if (w_stat_wr && dataBusOut[3])   r_overflow <= 1'b0;
        end
    end

    assign txValid = !w_empty;
    assign txData  = w_empty ? 8'h00 : r_fifo[r_rptr];

    // ---------------- load pipeline ----------------
    logic        r_s1_valid, r_s1_zero, r_s1_stat_rd;
    logic        r_s1_byte, r_s1_half, r_s1_uns;
    logic [1:0]  r_s1_lane;
    logic [3:0]  r_s1_status;
    logic        r_s2_valid;
    logic [31:0] r_s2_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    always_comb begin
        w_byte = 8'h00;
        w_fmt  = '0;
        case (r_s1_lane)
            2'd0: w_byte = r_rdata[7:0];
            2'd1: w_byte = r_rdata[15:8];
            2'd2: w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_s1_lane[1] ? r_rdata[31:16] : r_rdata[15:0];
        if (r_s1_stat_rd) begin
            w_fmt = {28'h0, r_s1_status};
        end else if (!r_s1_zero) begin
            if (r_s1_byte)      w_fmt = {{24{w_byte[7] & ~r_s1_uns}}, w_byte};
            else if (r_s1_half) w_fmt = {{16{w_half[15] & ~r_s1_uns}}, w_half};
            else                w_fmt = r_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_s1_valid   <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_stat_rd <= 1'b0;
            r_s1_byte    <= 1'b0;
            r_s1_half    <= 1'b0;
            r_s1_uns     <= 1'b0;
            r_s1_lane    <= 2'b00;
            r_s1_status  <= 4'h0;
            r_s2_valid   <= 1'b0;
            r_s2_data    <= '0;
        end else begin
            r_s1_valid   <= w_rd;
            // Invalid mode, misaligned, or a UART register other than STATUS reads as 0.
            r_s1_zero    <= !(w_ram_rd || w_stat_rd);
            r_s1_stat_rd <= w_stat_rd;
            r_s1_byte    <= w_is_byte;
            r_s1_half    <= w_is_half;
            r_s1_uns     <= RamMode[0];
            r_s1_lane    <= addr[1:0];
            // STATUS snapshot is the pre-edge state; this cycle's push shows next time.
            r_s1_status  <= {r_overflow, r_misalign, w_empty, w_full};
            r_s2_valid   <= r_s1_valid;
            r_s2_data    <= r_s1_valid ? w_fmt : 32'h0;
        end
    end

    assign dataBusIn   = r_s2_data;
    assign dataBusInEn = r_s2_valid;

endmodule
